// File: rtl/pid_coef_loader.sv
// pid_coef_loader: byte-serial loader for the five PID filter coefficients.
// Coefficients are written LSB-first into shadow registers through a
// valid/ready byte stream. A commit command arms the loader, and the next
// pid_tick_i copies all five shadows into the active outputs at once, so the
// PID datapath never sees a half-updated coefficient set.
module pid_coef_loader #(
    parameter int REG_BITWIDTH = 32,
    parameter int NBYTES       = REG_BITWIDTH / 8
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [7:0]                     cfg_data_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic                           pid_tick_i,
    output logic signed [REG_BITWIDTH-1:0] a0_o,
    output logic signed [REG_BITWIDTH-1:0] a1_o,
    output logic signed [REG_BITWIDTH-1:0] b0_o,
    output logic signed [REG_BITWIDTH-1:0] b1_o,
    output logic signed [REG_BITWIDTH-1:0] b2_o,
    output logic                           busy_o,
    output logic                           commit_done_o,
    output logic                           err_o
);

    localparam int NCOEF = 5;
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       OP_WRITE  = 4'h1;
    localparam logic [3:0]       OP_COMMIT = 4'h2;
    localparam logic [3:0]       IDX_MAX   = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA      = 2'd1,
        ST_WAIT_TICK = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [2:0]              idx_r;
    logic [REG_BITWIDTH-1:0] shadow_r [NCOEF];
    logic [REG_BITWIDTH-1:0] active_r [NCOEF];
    logic                    ready_r;
    logic                    busy_r;
    logic                    commit_done_r;
    logic                    err_r;

    logic                    accept_s;
    logic [3:0]              opcode_s;
    logic [3:0]              index_s;
    logic                    index_ok_s;

    // Command byte decode and handshake qualification.
    always_comb begin
        accept_s   = cfg_valid_i & ready_r;
        opcode_s   = cfg_data_i[7:4];
        index_s    = cfg_data_i[3:0];
        index_ok_s = (index_s <= IDX_MAX);
    end

    // Loader FSM; also owns shadow/active registers and all registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            idx_r         <= 3'd0;
            ready_r       <= 1'b1;
            busy_r        <= 1'b0;
            commit_done_r <= 1'b0;
            err_r         <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else begin
            // Status pulses last exactly one cycle unless re-armed below.
            commit_done_r <= 1'b0;
            err_r         <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // pid_tick_i is deliberately ignored here, which also keeps a
                    // tick coincident with the commit byte from applying it.
                    if (accept_s) begin
                        if ((opcode_s == OP_WRITE) && index_ok_s) begin
                            idx_r   <= index_s[2:0];
                            cnt_r   <= '0;
                            state_r <= ST_DATA;
                            busy_r  <= 1'b1;
                        end else if (opcode_s == OP_COMMIT) begin
                            state_r <= ST_WAIT_TICK;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // Every byte here is payload; no opcode decode.
                    if (accept_s) begin
                        shadow_r[idx_r][{cnt_r, 3'b000} +: 8] <= cfg_data_i;
                        if (cnt_r == CNT_LAST) begin
                            cnt_r   <= '0;
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_WAIT_TICK: begin
                    if (pid_tick_i) begin
                        for (int i = 0; i < NCOEF; i++) begin
                            active_r[i] <= shadow_r[i];
                        end
                        commit_done_r <= 1'b1;
                        state_r       <= ST_IDLE;
                        ready_r       <= 1'b1;
                        busy_r        <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o   = ready_r;
    assign busy_o        = busy_r;
    assign commit_done_o = commit_done_r;
    assign err_o         = err_r;
    assign a0_o          = active_r[0];
    assign a1_o          = active_r[1];
    assign b0_o          = active_r[2];
    assign b1_o          = active_r[3];
    assign b2_o          = active_r[4];

endmodule

// File: tb/tb_pid_coef_loader.sv
// Directed testbench for pid_coef_loader.
module tb_pid_coef_loader;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [7:0]  cfg_data_i = 8'h00;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic        pid_tick_i = 1'b0;
    logic signed [31:0] a0_o, a1_o, b0_o, b1_o, b2_o;
    logic        busy_o;
    logic        commit_done_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    int cd_cnt = 0;
    int err_cnt = 0;

    pid_coef_loader #(.REG_BITWIDTH(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .pid_tick_i(pid_tick_i),
        .a0_o(a0_o), .a1_o(a1_o), .b0_o(b0_o), .b1_o(b1_o), .b2_o(b2_o),
        .busy_o(busy_o), .commit_done_o(commit_done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Count pulse cycles away from the active edge.
    always @(negedge clk_i) begin
        if (commit_done_o === 1'b1) cd_cnt++;
        if (err_o === 1'b1) err_cnt++;
    end

    // Offer one byte and hold it until the DUT accepts it (bounded).
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   budget;
        for (int g = 0; g < gap; g++) begin
            cfg_valid_i = 1'b0;
            @(posedge clk_i); #1;
        end
        cfg_data_i  = b;
        cfg_valid_i = 1'b1;
        budget = 0;
        do begin
            rdy = cfg_ready_o;
            @(posedge clk_i); #1;
            budget++;
        end while (!rdy && budget < 20);
        cfg_valid_i = 1'b0;
        if (!rdy) begin
            errors++;
            $display("FAIL send_byte_timeout: byte %02h not accepted, ready=%b", b, cfg_ready_o);
        end
    endtask

    task automatic tick();
        pid_tick_i = 1'b1;
        @(posedge clk_i); #1;
        pid_tick_i = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] idx, input logic [31:0] v, input int gap);
        send_byte({4'h1, idx}, gap);
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gap);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        #12;
        checks++;
        if ({cfg_ready_o, busy_o, commit_done_o, err_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_status: got rdy/busy/cd/err=%b want 1000",
                     {cfg_ready_o, busy_o, commit_done_o, err_o});
        end
        checks++;
        if ({a0_o, a1_o, b0_o, b1_o, b2_o} !== 160'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %h %h %h %h want all 0", a0_o, a1_o, b0_o, b1_o, b2_o);
        end
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_errors();
        int e0;
        e0 = err_cnt;
        send_byte(8'h15, 0);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_bad_index: got err=%b busy=%b want err=1 busy=0", err_o, busy_o);
        end
        send_byte(8'h30, 0);
        @(posedge clk_i); #1;
        checks++;
        if (err_cnt - e0 !== 2) begin
            errors++;
            $display("FAIL err_pulse_count: got %0d want 2", err_cnt - e0);
        end
        checks++;
        if ({a0_o, a1_o, b0_o, b1_o, b2_o} !== 160'd0 || busy_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL err_no_effect: outs %h %h %h %h %h busy=%b rdy=%b", a0_o, a1_o, b0_o, b1_o, b2_o, busy_o, cfg_ready_o);
        end
    endtask

    task automatic test_write_commit();
        int c0;
        c0 = cd_cnt;
        write_coef(4'd0, 32'h12345678, 0);
        checks++;
        if (a0_o !== 32'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL shadow_hidden: got a0=%h busy=%b want a0=0 busy=0", a0_o, busy_o);
        end
        send_byte(8'h20, 0);
        checks++;
        if (busy_o !== 1'b1 || cfg_ready_o !== 1'b0 || a0_o !== 32'h0) begin
            errors++;
            $display("FAIL wait_tick_state: got busy=%b rdy=%b a0=%h want 1 0 0", busy_o, cfg_ready_o, a0_o);
        end
        tick();
        checks++;
        if (a0_o !== 32'h12345678 || commit_done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL commit_a0: got a0=%h cd=%b busy=%b want 12345678 1 0", a0_o, commit_done_o, busy_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (commit_done_o !== 1'b0 || cd_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL commit_pulse_once: got cd=%b count=%0d want 0 1", commit_done_o, cd_cnt - c0);
        end
        // Commit without new writes reloads the unchanged shadows.
        send_byte(8'h20, 0);
        tick();
        checks++;
        if (a0_o !== 32'h12345678 || commit_done_o !== 1'b1 || a1_o !== 32'h0) begin
            errors++;
            $display("FAIL empty_commit: got a0=%h a1=%h cd=%b want 12345678 0 1", a0_o, a1_o, commit_done_o);
        end
    endtask

    task automatic test_tick_coincide();
        int c0;
        write_coef(4'd4, 32'hCAFEF00D, 0);
        c0 = cd_cnt;
        tick();                       // tick in IDLE is ignored
        @(posedge clk_i); #1;
        checks++;
        if (cd_cnt !== c0 || b2_o !== 32'h0) begin
            errors++;
            $display("FAIL tick_idle_ignored: got cd_count=%0d b2=%h want %0d 0", cd_cnt, b2_o, c0);
        end
        cfg_data_i  = 8'h20;
        cfg_valid_i = 1'b1;
        pid_tick_i  = 1'b1;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        pid_tick_i  = 1'b0;
        checks++;
        if (b2_o !== 32'h0 || commit_done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL coincide_no_commit: got b2=%h cd=%b busy=%b want 0 0 1", b2_o, commit_done_o, busy_o);
        end
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (cfg_ready_o !== 1'b0 || b2_o !== 32'h0) begin
            errors++;
            $display("FAIL wait_ready_low: got rdy=%b b2=%h want 0 0", cfg_ready_o, b2_o);
        end
        tick();
        checks++;
        if (b2_o !== 32'hCAFEF00D || a0_o !== 32'h12345678 || commit_done_o !== 1'b1) begin
            errors++;
            $display("FAIL coincide_next_tick: got b2=%h a0=%h cd=%b want cafef00d 12345678 1", b2_o, a0_o, commit_done_o);
        end
    endtask

    task automatic test_random_valid();
        logic [31:0] vals [5];
        logic [31:0] got  [5];
        vals[0] = 32'h11223344; vals[1] = 32'h80000001; vals[2] = 32'hDEADBEEF;
        vals[3] = 32'h0000FFFF; vals[4] = 32'h7FFFFFFF;
        for (int i = 0; i < 5; i++) write_coef(4'(i), vals[i], int'($urandom_range(0, 2)));
        checks++;
        if (a0_o !== 32'h12345678 || b2_o !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL random_pre_commit: got a0=%h b2=%h want 12345678 cafef00d", a0_o, b2_o);
        end
        send_byte(8'h20, 2);
        tick();
        got[0] = a0_o; got[1] = a1_o; got[2] = b0_o; got[3] = b1_o; got[4] = b2_o;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== vals[i]) begin
                errors++;
                $display("FAIL random_coef%0d: got %h want %h", i, got[i], vals[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int c0;
        send_byte(8'h13, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || cfg_ready_o !== 1'b1 || a0_o !== 32'h0 || b1_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_write: got busy=%b rdy=%b a0=%h b1=%h want 0 1 0 0", busy_o, cfg_ready_o, a0_o, b1_o);
        end
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        send_byte(8'h20, 0);
        c0 = cd_cnt;
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_wait: got busy=%b rdy=%b want 0 1", busy_o, cfg_ready_o);
        end
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        tick();
        @(posedge clk_i); #1;
        checks++;
        if (cd_cnt !== c0 || {a0_o, a1_o, b0_o, b1_o, b2_o} !== 160'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_no_commit: cd_count=%0d (want %0d) outs %h %h %h %h %h busy=%b",
                     cd_cnt, c0, a0_o, a1_o, b0_o, b1_o, b2_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_errors();
        test_write_commit();
        test_tick_coincide();
        test_random_valid();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_coef_loader.md
PID_COEF_LOADER -- requirements
Module: pid_coef_loader

Interface
REQ-001 Parameter: REG_BITWIDTH, default 32, coefficient width; SHALL be a multiple of 8.
REQ-002 Parameter: NBYTES, default REG_BITWIDTH/8, data bytes per coefficient write.
REQ-003 Port: clk_i  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port: rstn_i  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 Port: cfg_data_i  in  8  command/data byte.
REQ-006 Port: cfg_valid_i  in  1  cfg_data_i is valid.
REQ-007 Port: cfg_ready_o  out  1  loader accepts a byte this cycle.
REQ-008 Port: pid_tick_i  in  1  one-cycle strobe marking a PID update boundary.
REQ-009 Port: a0_o, a1_o, b0_o, b1_o, b2_o  out  REG_BITWIDTH signed each  active coefficients.
REQ-010 Port: busy_o  out  1  high whenever state != IDLE.
REQ-011 Port: commit_done_o  out  1  one-cycle pulse when active coefficients are updated.
REQ-012 Port: err_o  out  1  one-cycle pulse on a rejected command byte.

Function
REQ-013 A byte SHALL be accepted only on a cycle with cfg_valid_i=1 and cfg_ready_o=1.
REQ-014 cfg_ready_o SHALL be 1 in IDLE and DATA, and 0 in WAIT_TICK.
REQ-015 The FSM SHALL have exactly three states: IDLE, DATA, WAIT_TICK.
REQ-016 Command byte: bits[7:4] are the opcode and bits[3:0] are the index.
REQ-017 Opcode 0x1 with index 0..4 (0=a0, 1=a1, 2=b0, 3=b1, 4=b2) SHALL latch the index, clear the byte counter and move IDLE->DATA.
REQ-018 In DATA, each accepted byte SHALL be written LSB-first into shadow[index] at bits [8*cnt+7 : 8*cnt].
REQ-019 After the NBYTES-th data byte is accepted, the FSM SHALL return to IDLE; in DATA every byte is data, and no opcode is decoded.
REQ-020 Opcode 0x2 (commit) accepted in IDLE SHALL move the FSM to WAIT_TICK.
REQ-021 In WAIT_TICK, on the first edge with pid_tick_i=1:
- all five active registers SHALL load their shadow values;
- commit_done_o SHALL be 1 for exactly that following cycle;
- the FSM SHALL return to IDLE.
REQ-022 A pid_tick_i that coincides with acceptance of the commit byte SHALL NOT apply the commit; the next tick SHALL.
REQ-023 Rejected commands SHALL consume the byte, pulse err_o for one cycle, leave the FSM in IDLE, and change no register. Rejected commands are:
- any opcode other than 0x1 or 0x2;
- opcode 0x1 with an index greater than 4.
REQ-024 Active outputs SHALL change only on commit; shadow writes SHALL NOT be visible on a0_o..b2_o.
REQ-025 A commit with no preceding writes SHALL re-load the unchanged shadow values and still pulse commit_done_o.
REQ-026 pid_tick_i SHALL be ignored in IDLE and DATA.
REQ-027 A partially written shadow register (interrupted only by reset) is undefined until rewritten; active registers SHALL be unaffected.

Reset
REQ-028 While rstn_i=0, the block SHALL hold:
- state IDLE, byte counter 0, index 0;
- all shadow and active registers 0;
- cfg_ready_o=1, busy_o=0, commit_done_o=0, err_o=0.
REQ-029 Reset asserted mid-write or in WAIT_TICK SHALL abandon the operation immediately, with no commit.

Verification
REQ-030 Write 0x10, 0x78, 0x56, 0x34, 0x12, then commit 0x20, then pid_tick_i pulse -> a0_o=0x12345678 one cycle after the tick; commit_done_o pulses once; a0_o stays 0 before the tick.
REQ-031 Byte 0x15, then byte 0x30 -> err_o pulses twice; FSM stays IDLE; all outputs remain 0.
REQ-032 Commit byte accepted in the same cycle as pid_tick_i -> no update at that tick; update at the next tick; cfg_ready_o=0 throughout WAIT_TICK.
REQ-033 cfg_valid_i toggled randomly during a 5-coefficient load plus commit -> all five outputs match the written values after the tick; no byte lost or duplicated.
REQ-034 rstn_i pulsed low after 2 data bytes of a b1 write and again in WAIT_TICK -> FSM in IDLE, busy_o=0, outputs 0, no commit_done_o pulse.
